// File: rtl/elem_pkg.sv
// Shared definitions for the row write-back block.
//
// Build-time macros (each may be overridden on the command line):
//   DATA_SIZE  element width in bits            (default 8)
//   ADDR_SIZE  SRAM address width                (default 20)
//   INPUT_NUM  elements per input block          (default 12)
//   ROW_NUM    elements per SRAM row             (default 24)
//   ADDR_BASE  first write address               (default 0)
//   ADDR_OFFU  address increment per row         (default 1)
// Optional feature macro: ELEM_ROW_WB_FLUSH_EN (used by elem_row_wb).
//
// Contents: the BLK_NUM constant, the block/row/address vector typedefs, the
// block-index typedef and the hold-register state enum.

`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 20
`endif
`ifndef INPUT_NUM
`define INPUT_NUM 12
`endif
`ifndef ROW_NUM
`define ROW_NUM 24
`endif
`ifndef ADDR_BASE
`define ADDR_BASE 0
`endif
`ifndef ADDR_OFFU
`define ADDR_OFFU 1
`endif

package elem_pkg;

    localparam int DATA_SIZE = `DATA_SIZE;
    localparam int ADDR_SIZE = `ADDR_SIZE;
    localparam int INPUT_NUM = `INPUT_NUM;
    localparam int ROW_NUM   = `ROW_NUM;
    localparam int ADDR_BASE = `ADDR_BASE;
    localparam int ADDR_OFFU = `ADDR_OFFU;

    // Number of input blocks that make up one SRAM row.
    localparam int BLK_NUM  = ROW_NUM / INPUT_NUM;
    // The block index keeps at least one bit so BLK_NUM=1 still elaborates.
    localparam int BLK_W    = (BLK_NUM > 1) ? $clog2(BLK_NUM) : 1;
    localparam int BLK_BITS = INPUT_NUM * DATA_SIZE;
    localparam int ROW_BITS = ROW_NUM * DATA_SIZE;

    typedef logic [BLK_BITS-1:0]  blk_t;
    typedef logic [ROW_BITS-1:0]  row_t;
    typedef logic [ADDR_SIZE-1:0] addr_t;
    typedef logic [BLK_W-1:0]     idx_t;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_t;

endpackage

// File: rtl/elem_row_hold.sv
// Hold register for one completed row plus its SRAM write handshake.
//
// Handshake: wr_en=1 means wr_data is a pending row write; the write completes
// on a rising edge where wr_en & wr_ready. While wr_en=1 and wr_ready=0 the
// row is held unchanged. wr_ready while wr_en=0 is ignored.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   load        a completed row is presented this cycle (the caller only
//               asserts it when the register is EMPTY or being drained)
//   load_data   the completed row
//   wr_ready    SRAM accepts the pending write this cycle
//   wr_en       pending write request (state == HOLD_FULL)
//   wr_data     held row
//   state       FSM state, exported for observation and for the top's stall logic

module elem_row_hold
    import elem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  row_t        load_data,
    input  logic        wr_ready,
    output logic        wr_en,
    output row_t        wr_data,
    output hold_state_t state
);

    hold_state_t state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HOLD_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            HOLD_EMPTY: begin
                if (load) begin
                    state_next = HOLD_FULL;
                end
            end
            HOLD_FULL: begin
                // A drain and a new row on the same edge keep the register full.
                if (wr_ready && !load) begin
                    state_next = HOLD_EMPTY;
                end
            end
            default: state_next = HOLD_EMPTY;
        endcase
    end

    assign wr_en = (state == HOLD_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_data <= '0;
        end else if (load) begin
            wr_data <= load_data;
        end
    end

endmodule

// File: rtl/elem_row_wb.sv
// Row write-back: collects BLK_NUM input blocks of INPUT_NUM elements into one
// SRAM row and writes it through a single-entry hold register.
//
// Input handshake: a block is accepted on a rising edge where
// in_data_valid & in_ready. in_ready drops only when the incoming block would
// complete a row while the hold register is full and not draining.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   in_data_valid   data_in carries a valid block
//   data_in         block, element 0 at the LSBs
//   in_ready        block accepted when in_data_valid & in_ready
//   wr_ready        SRAM accepts the pending write this cycle
//   wr_en           row write request
//   wr_addr         row write address (ADDR_BASE, stepping by ADDR_OFFU)
//   wr_data         assembled row
//   row_cnt         rows written since reset
//   flush           (only with ELEM_ROW_WB_FLUSH_EN) close a partial row,
//                   zero-filling the missing elements
//
// Optional feature macro: ELEM_ROW_WB_FLUSH_EN.

module elem_row_wb
    import elem_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  in_data_valid,
    input  blk_t  data_in,
    output logic  in_ready,
    input  logic  wr_ready,
    output logic  wr_en,
    output addr_t wr_addr,
    output row_t  wr_data,
    output addr_t row_cnt
`ifdef ELEM_ROW_WB_FLUSH_EN
    ,
    input  logic  flush
`endif
);

    generate
        if ((ROW_NUM < INPUT_NUM) || ((ROW_NUM % INPUT_NUM) != 0)) begin : g_bad_cfg
            $error("elem_row_wb: ROW_NUM must be a non-zero multiple of INPUT_NUM");
        end
    endgenerate

    idx_t        blk_idx;
    row_t        asm_buf;
    row_t        merged;
    hold_state_t hold_state;
    logic        last_blk;
    logic        can_load;
    logic        accept;
    logic        flush_go;
    logic        complete;
    logic        fire;

    assign last_blk = (blk_idx == idx_t'(BLK_NUM - 1));
    // The hold register can take a new row if it is empty or drains this edge.
    assign can_load = (hold_state == HOLD_EMPTY) || wr_ready;
    assign in_ready = !last_blk || can_load;
    assign accept   = in_data_valid && in_ready;
    assign fire     = wr_en && wr_ready;

`ifdef ELEM_ROW_WB_FLUSH_EN
    // Nothing to flush at blk_idx=0 unless a block arrives in the same cycle.
    assign flush_go = flush && ((blk_idx != '0) || accept) && can_load;
`else
    assign flush_go = 1'b0;
`endif

    assign complete = (accept && last_blk) || flush_go;

    // Current buffer with the incoming block dropped into its slot. Slots past
    // blk_idx are always zero because the buffer is cleared on completion,
    // which provides the zero fill for flushed rows.
    always_comb begin
        merged = asm_buf;
        if (accept) begin
            for (int b = 0; b < BLK_NUM; b++) begin
                if (blk_idx == idx_t'(b)) begin
                    merged[b*BLK_BITS +: BLK_BITS] = data_in;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_idx <= '0;
            asm_buf <= '0;
        end else if (complete) begin
            blk_idx <= '0;
            asm_buf <= '0;
        end else if (accept) begin
            blk_idx <= blk_idx + idx_t'(1);
            asm_buf <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr <= addr_t'(ADDR_BASE);
            row_cnt <= '0;
        end else if (fire) begin
            wr_addr <= wr_addr + addr_t'(ADDR_OFFU);
            row_cnt <= row_cnt + addr_t'(1);
        end
    end

    elem_row_hold u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (complete),
        .load_data (merged),
        .wr_ready  (wr_ready),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .state     (hold_state)
    );

endmodule

// File: doc/elem_row_wb.md
ELEM_ROW_WB -- requirements
Module: elem_row_wb

Interface
REQ-001 Macro DATA_SIZE, default 8, element width in bits.
REQ-002 Macro ADDR_SIZE, default 20, SRAM address width.
REQ-003 Macro INPUT_NUM, default 12, elements per input block.
REQ-004 Macro ROW_NUM, default 24, elements per SRAM row; must be a multiple of INPUT_NUM and at least INPUT_NUM.
REQ-005 Macro ADDR_BASE, default 0, first write address.
REQ-006 Macro ADDR_OFFU, default 1, address increment per row.
REQ-007 clk  in  1  single clock; all logic on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 in_data_valid  in  1  data_in carries a valid block.
REQ-010 data_in  in  INPUT_NUM*DATA_SIZE  result block (element 0 at LSBs).
REQ-011 in_ready  out  1  block accepted when in_data_valid & in_ready.
REQ-012 wr_ready  in  1  SRAM accepts the write this cycle.
REQ-013 wr_en  out  1  row write request.
REQ-014 wr_addr  out  ADDR_SIZE  row write address.
REQ-015 wr_data  out  ROW_NUM*DATA_SIZE  assembled row.
REQ-016 row_cnt  out  ADDR_SIZE  rows written since reset.

Function
REQ-017 Let BLK_NUM = ROW_NUM/INPUT_NUM; blk_idx counts 0..BLK_NUM-1 and places each accepted block at elements [blk_idx*INPUT_NUM +: INPUT_NUM] of the assembly buffer.
REQ-018 On acceptance, blk_idx increments, wrapping to 0 after BLK_NUM-1.
REQ-019 Accepting block BLK_NUM-1 moves the completed row (including that block) into the hold register in the same edge; wr_en rises the next cycle (latency 1 cycle from last-block acceptance).
REQ-020 Hold-register states: EMPTY (wr_en=0) and FULL (wr_en=1); EMPTY->FULL on row completion; FULL->EMPTY on wr_ready without a new completion; FULL->FULL when wr_ready and a new completion coincide.
REQ-021 in_ready = 1 when blk_idx != BLK_NUM-1, or the hold register is EMPTY, or wr_ready=1.
REQ-022 wr_data and wr_addr hold stable while wr_en=1 and wr_ready=0.
REQ-023 wr_addr starts at ADDR_BASE and increases by ADDR_OFFU on each completed write (wr_en & wr_ready); it wraps modulo 2^ADDR_SIZE.
REQ-024 row_cnt increments on each completed write and wraps modulo 2^ADDR_SIZE.
REQ-025 wr_ready while wr_en=0 has no effect.
REQ-026 When BLK_NUM=1, every accepted block is a complete row.

Reset
REQ-027 While rst=1 at a clock edge: wr_en=0, wr_addr=ADDR_BASE, wr_data=0, row_cnt=0, blk_idx=0, assembly buffer cleared, and hold register EMPTY.
REQ-028 Reset mid-row or mid-write discards the partial row and the pending write without emitting them.
REQ-029 in_ready=1 in the first cycle after reset.

Configuration
REQ-030 Macro ELEM_ROW_WB_FLUSH_EN adds input port flush (1 bit).
REQ-031 With the macro defined, flush=1 with blk_idx!=0 completes the partial row as in REQ-019, with unfilled elements set to 0, and resets blk_idx to 0.
REQ-032 If flush and an accepted block coincide, the block is included in the flushed row.
REQ-033 A flush is stalled under the same hold-register condition as REQ-021; flush with blk_idx=0 and no accepted block does nothing.
REQ-034 With the macro undefined, the flush port is absent and only complete rows are written.

Structure
REQ-035 A shared package elem_pkg holds the BLK_NUM constant, the block and row vector typedefs, and the address typedef.
REQ-036 One sub-module, elem_row_hold, implements the hold register and its wr_en/wr_ready handshake; assembly and counters live in the top.
REQ-037 Elaboration reports an error if ROW_NUM is not a multiple of INPUT_NUM or ROW_NUM < INPUT_NUM.

Verification (defaults: BLK_NUM=2)
REQ-038 Blocks A, B on consecutive cycles with wr_ready=1 -> wr_en=1 one cycle after B, wr_data={B,A}, wr_addr=0; then wr_addr=1 and row_cnt=1.
REQ-039 Four blocks back-to-back with wr_ready=0 -> first row held stable; in_ready=0 while the 4th block is waiting; raising wr_ready -> two writes in order at addr 0 then 1.
REQ-040 Block A, then rst, then blocks C, D -> single write {D,C} at addr 0; A is never written.
REQ-041 With ADDR_SIZE=2 and 5 rows written -> addresses 0,1,2,3,0; row_cnt wraps to 1.
REQ-042 With ELEM_ROW_WB_FLUSH_EN: block A then flush -> wr_data={0,A}, blk_idx returns to 0; next A2, B2 -> written at addr 1.
REQ-043 wr_ready toggles randomly while valid blocks stream -> no block lost or duplicated, and addresses are contiguous.
